// File: rtl/complex_word_reader.sv
// complex_word_reader: buffers packed {real, imag} words and serializes them real-first onto a valid/ready bus
module complex_word_reader #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [2*DATA_W-1:0]       in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         out_word,
  output logic                      out_is_imag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, REAL = 2'd1, IMAG = 2'd2;
  logic [1:0] state;
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [2*DATA_W-1:0] head;
  logic [DATA_W-1:0] hold;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign in_ready = level != (AW+1)'(DEPTH);
  assign push = in_valid && in_ready;
  // a pop loads the next word straight into the output stage, so IDLE and IMAG->REAL share it
  assign pop = level != '0 && (state == IDLE || (state == IMAG && out_ready));
  assign head = mem[rd_ptr];
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      hold        <= '0;
      out_word    <= '0;
      out_is_imag <= 1'b0;
      out_valid   <= 1'b0;
      state       <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) begin
        hold        <= head[DATA_W-1:0];
        out_word    <= head[2*DATA_W-1:DATA_W];
        out_is_imag <= 1'b0;
        out_valid   <= 1'b1;
        state       <= REAL;
      end else if (state == REAL && out_ready) begin
        out_word    <= hold;
        out_is_imag <= 1'b1;
        state       <= IMAG;
      end else if (state == IMAG && out_ready) begin
        out_valid   <= 1'b0;
        state       <= IDLE;
      end
    end
endmodule

// File: tb/tb_complex_word_reader.sv
// tb_complex_word_reader: directed stimulus with a component scoreboard for complex_word_reader
module tb_complex_word_reader;
  logic        clock = 1'b0, reset = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] out_word;
  logic        out_is_imag, out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  level;
  int total = 0, bad = 0, run = 0, last_run = 0;
  logic [32:0] sb [$];

  always #5 clock = ~clock;

  complex_word_reader #(.DEPTH(4), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_word(out_word), .out_is_imag(out_is_imag), .out_valid(out_valid), .out_ready(out_ready),
    .level(level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // handshakes seen here complete on the coming rising edge
  task automatic tick();
    logic [32:0] e;
    if (in_valid && in_ready && reset) begin
      sb.push_back({1'b0, in_data[63:32]});
      sb.push_back({1'b1, in_data[31:0]});
    end
    if (out_valid && out_ready) begin
      e = 'x;
      if (sb.size() != 0) e = sb.pop_front();
      chk("out_component", {31'b0, out_is_imag, out_word}, {31'b0, e});
    end
    if (out_valid) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, {32'(sb.size()), 31'b0, out_valid}, 64'h0);
    chk({tag, "_level"}, 64'(level), 64'h0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_out", {out_valid, out_is_imag, out_word}, 64'h0);
    chk("rst_level", 64'(level), 64'h0);
    reset = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    in_data = 64'h00000005_FFFFFFFD;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("single_real", {out_valid, out_is_imag, out_word}, {30'b0, 1'b1, 1'b0, 32'h00000005});
    tick();
    chk("single_imag", {out_valid, out_is_imag, out_word}, {30'b0, 1'b1, 1'b1, 32'hFFFFFFFD});
    tick();
    chk("single_idle", {61'b0, out_valid, level}, 64'h0);

    run = 0;
    last_run = 0;
    for (int i = 0; i < 3; i++) begin
      in_data = {32'(2*i+1), 32'(2*i+2)};
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    drain("b2b");
    tick();
    chk("b2b_no_bubble", 64'(last_run), 64'd6);

    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_data = {32'hA0000000 + 32'(i), 32'hB0000000 + 32'(i)};
      in_valid = 1'b1;
      if (i == 5) chk("full_in_ready_low", 64'(in_ready), 64'h0);
      tick();
      if (i == 4) chk("full_level", {60'b0, in_ready, level}, {60'b0, 1'b0, 3'd4});
    end
    in_valid = 1'b0;
    chk("full_hold_level", 64'(level), 64'd4);
    out_ready = 1'b1;
    tick();
    chk("full_no_pop_yet", 64'(in_ready), 64'h0);
    tick();
    chk("full_after_pop", {60'b0, in_ready, level}, {60'b0, 1'b1, 3'd3});
    drain("full");

    out_ready = 1'b0;
    in_data = 64'hAAAA0000_5555FFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("bp_real", {out_valid, out_is_imag, out_word}, {30'b0, 1'b1, 1'b0, 32'hAAAA0000});
    repeat (3) begin
      tick();
      chk("bp_stable", {out_valid, out_is_imag, out_word}, {30'b0, 1'b1, 1'b0, 32'hAAAA0000});
    end
    out_ready = 1'b1;
    tick();
    chk("bp_imag", {out_valid, out_is_imag, out_word}, {30'b0, 1'b1, 1'b1, 32'h5555FFFF});
    drain("bp");

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = {32'hE0000000 + 32'(i), 32'hF0000000 + 32'(i)};
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("wrap_start_level", 64'(level), 64'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      in_data = {32'hC0000000 + 32'(k), 32'hD0000000 + 32'(k)};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("wrap_level", 64'(level), 64'd2);
    end
    drain("wrap");

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = {32'h11110000 + 32'(i), 32'h22220000 + 32'(i)};
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mid_pre_state", {60'b0, out_is_imag, level}, {60'b0, 1'b1, 3'd3});
    #2 reset = 1'b0;
    #1;
    chk("mid_async_clear", {out_valid, level, out_word}, 64'h0);
    sb.delete();
    run = 0;
    tick();
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("mid_no_stale", 64'(out_valid), 64'h0);
    end
    in_data = 64'h12345678_9ABCDEF0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain("mid_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/complex_word_reader.md
Name: complex_word_reader

Overview:
- Consumer-side reader for the packed 64-bit complex result word {Real[31:0], Im[31:0]} produced by the complex add/sub stage.
- Buffers incoming results in a small FIFO.
- Serializes each result onto a 32-bit output bus, real part first and imaginary part second, using a valid/ready handshake.
- Sits between the arithmetic stage and the 32-bit downstream bus / memory writer.

Parameters:
- DEPTH, 4, FIFO entries. Power of two, minimum 2.
- DATA_W, 32, width of each real/imaginary component. The packed input is 2*DATA_W wide.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  2*DATA_W  packed complex word; [2*DATA_W-1:DATA_W] = real, [DATA_W-1:0] = imaginary.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a word; combinational, equals !full.
- out_word  output  DATA_W  current serialized component.
- out_is_imag  output  1  0 = out_word is the real part, 1 = out_word is the imaginary part.
- out_valid  output  1  out_word is valid.
- out_ready  input  1  downstream accepts out_word this cycle.
- level  output  $clog2(DEPTH)+1  FIFO occupancy; the hold register is not counted.

Behaviour:
- Clocking and reset
  - One clock domain.
  - reset low asynchronously clears: FIFO pointers, level=0, hold register=0, out_word=0, out_is_imag=0, out_valid=0, FSM=IDLE.
  - in_ready is 1 as soon as reset deasserts.
  - Reset mid-transfer discards all buffered and held data. No partial word is emitted after release.
- Push
  - Occurs on the rising edge when in_valid && in_ready; writes in_data at the write pointer.
  - Pointers wrap modulo DEPTH.
  - in_valid while full: no write, data ignored. The upstream must hold the word.
- Pop
  - Performed only by the FSM, as described below.
  - When push and pop occur in the same edge, level is unchanged.
  - When full, in_ready=0 even if a pop occurs that cycle. No same-cycle push-at-full.
- FSM states and transitions (all outputs registered)
  - IDLE: out_valid=0.
    - If level>0: pop; hold<=entry; out_word<=entry real; out_is_imag<=0; out_valid<=1; go to REAL.
  - REAL: out_word holds the real part.
    - If out_ready: out_word<=hold imaginary; out_is_imag<=1; go to IMAG.
    - Else hold all outputs.
  - IMAG: out_word holds the imaginary part.
    - If out_ready and level>0: pop next entry; load its real part into out_word and the new hold; out_is_imag<=0; go to REAL.
    - If out_ready and level==0: out_valid<=0; go to IDLE.
    - Else hold all outputs.
- Handshake rule: while out_valid=1 and out_ready=0, out_word and out_is_imag are stable.
- Latency: a word pushed into an empty reader in IDLE at edge N produces out_valid=1 with its real part after edge N+1.
- Throughput: one complex word per 2 cycles with out_ready held high. No bubble between consecutive words while the FIFO is non-empty.
- Capacity: DEPTH+1 complex words in flight (FIFO plus hold register).
- Data handling: no arithmetic on data. Bits pass unmodified; order is real then imaginary.

Test Plan:
- Reset and single word
  - Stimulus: reset low then high; push 0x00000005_FFFFFFFD with out_ready=1.
  - Required: in_ready=1 after reset; out_word=0x00000005 with out_is_imag=0; next cycle 0xFFFFFFFD with out_is_imag=1; then out_valid=0 and level=0.
- Back-to-back stream
  - Stimulus: push 0x1_2, 0x3_4, 0x5_6 (DATA_W components) on consecutive cycles; out_ready=1.
  - Required: out_word sequence 1,2,3,4,5,6 on 6 consecutive valid cycles; out_is_imag toggles 0,1,0,1,0,1.
- Fill to full
  - Stimulus: out_ready=0; push 6 words A..F.
  - Required: A goes to the hold register; B..E fill the FIFO; level=4 and in_ready=0 when E is written; F is not accepted.
  - Then raise out_ready: A..E drain in order; in_ready returns to 1 after the first FIFO pop.
- Backpressure stability
  - Stimulus: while in REAL with out_word=0xAAAA0000, drop out_ready for 3 cycles.
  - Required: out_word, out_is_imag and out_valid remain unchanged for all 3 cycles; the imaginary part follows one cycle after out_ready=1.
- Simultaneous push/pop and wrap
  - Stimulus: DEPTH=4, level=2; push on the same edge as the IMAG->REAL pop, repeated for 10 words.
  - Required: level stays 2 throughout; pointers wrap past entry 3; output order is preserved.
- Mid-operation reset
  - Stimulus: assert reset asynchronously (between clock edges) while in IMAG with level=3.
  - Required: out_valid=0, level=0, out_word=0 immediately.
  - After release, no stale data appears; the next pushed word is output first.
